// File: rtl/mux3_arb_pkg.sv
// mux3_arb_pkg: shared types and constants for the 3-input round-robin arbiter.
// Optional feature macro: MUX3_ARB_LOCK_EN (handled in mux3_rr_arbiter).
package mux3_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [1:0] SEL_D0 = 2'b00;
   localparam logic [1:0] SEL_D1 = 2'b01;
   localparam logic [1:0] SEL_D2 = 2'b10;

   localparam logic [2:0] OH_D0 = 3'b001;
   localparam logic [2:0] OH_D1 = 3'b010;
   localparam logic [2:0] OH_D2 = 3'b100;

   function automatic logic [2:0] idx2oh(input logic [1:0] i);
      logic [2:0] oh;
      unique case (i)
         SEL_D0:  oh = OH_D0;
         SEL_D1:  oh = OH_D1;
         default: oh = OH_D2;
      endcase
      return oh;
   endfunction

   function automatic logic [1:0] nxt(input logic [1:0] i);
      logic [1:0] n;
      unique case (i)
         SEL_D0:  n = SEL_D1;
         SEL_D1:  n = SEL_D2;
         default: n = SEL_D0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mux3_rr_pick.sv
// mux3_rr_pick: combinational round-robin winner search.
// Order is last+1, last+2, then last itself unless excluded.
module mux3_rr_pick
   import mux3_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   input  logic       excl,
   output logic [1:0] win,
   output logic       found
);

   logic [1:0] c1;
   logic [1:0] c2;

   assign c1 = nxt(last);
   assign c2 = nxt(c1);

   // First pending requester after the previous owner wins.
   always_comb begin
      win   = last;
      found = 1'b0;
      if (|(req & idx2oh(c1))) begin
         win   = c1;
         found = 1'b1;
      end else if (|(req & idx2oh(c2))) begin
         win   = c2;
         found = 1'b1;
      end else if (!excl && |(req & idx2oh(last))) begin
         win   = last;
         found = 1'b1;
      end
   end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: 3-way round-robin arbiter with hold limit and data mux.
// Define MUX3_ARB_LOCK_EN to add the lock input that blocks forced rotation.
module mux3_rr_arbiter
   import mux3_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
`ifdef MUX3_ARB_LOCK_EN
   input  logic       lock,
`endif
   input  logic       d0,
   input  logic       d1,
   input  logic       d2,
   output logic [2:0] gnt,
   output logic [1:0] sel,
   output logic       y,
   output logic       valid
);

   localparam logic [7:0] HOLD = 8'(MAX_HOLD);

   state_t     state_q;
   state_t     state_d;
   logic [1:0] last_q;
   logic [1:0] last_d;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic [2:0] gnt_d;
   logic [1:0] sel_d;
   logic [1:0] win;
   logic       found;
   logic       excl;
   logic       own_req;
   logic       lk;
   logic       dsel;

`ifdef MUX3_ARB_LOCK_EN
   assign lk = lock;
`else
   assign lk = 1'b0;
`endif

   // While busy the current owner is skipped so a waiter can be found.
   assign excl    = (state_q == BUSY);
   assign own_req = |(req & idx2oh(last_q));

   mux3_rr_pick u_pick (
      .req   (req),
      .last  (last_q),
      .excl  (excl),
      .win   (win),
      .found (found)
   );

   // Next grant, owner pointer and hold count.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt;
      sel_d   = sel;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               gnt_d   = idx2oh(win);
               sel_d   = win;
               last_d  = win;
               cnt_d   = 8'd1;
            end
         end
         BUSY: begin
            if (!own_req) begin
               if (found) begin
                  gnt_d  = idx2oh(win);
                  sel_d  = win;
                  last_d = win;
                  cnt_d  = 8'd1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 3'b000;
                  cnt_d   = 8'd0;
               end
            end else if (found && cnt_q >= HOLD && !lk) begin
               gnt_d  = idx2oh(win);
               sel_d  = win;
               last_d = win;
               cnt_d  = 8'd1;
            end else if (cnt_q < HOLD) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Data of the currently selected requester.
   always_comb begin
      unique case (sel)
         SEL_D0:  dsel = d0;
         SEL_D1:  dsel = d1;
         default: dsel = d2;
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt     <= 3'b000;
         sel     <= SEL_D0;
         last_q  <= SEL_D2;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         gnt     <= gnt_d;
         sel     <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output data lags the grant by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y     <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= (gnt != 3'b000);
         y     <= (gnt != 3'b000) ? dsel : 1'b0;
      end
   end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb_mux3_rr_arbiter: directed checks of grant order, hold limit and reset.
// Define MUX3_ARB_LOCK_EN to also exercise the lock input.
module tb_mux3_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = 3'b000;
`ifdef MUX3_ARB_LOCK_EN
   logic       lock = 1'b0;
`endif
   logic       d0 = 1'b0;
   logic       d1 = 1'b0;
   logic       d2 = 1'b0;
   logic [2:0] gnt;
   logic [1:0] sel;
   logic       y;
   logic       valid;

   int n_chk = 0;
   int n_fail = 0;

   mux3_rr_arbiter #(.MAX_HOLD(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
`ifdef MUX3_ARB_LOCK_EN
      .lock  (lock),
`endif
      .d0    (d0),
      .d1    (d1),
      .d2    (d2),
      .gnt   (gnt),
      .sel   (sel),
      .y     (y),
      .valid (valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 3'b000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_chk++;
      if (gnt !== 3'b000 || sel !== 2'b00 || y !== 1'b0 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: gnt=%b sel=%b y=%b valid=%b want 000 00 0 0",
                  gnt, sel, y, valid);
      end
      do_reset();
   endtask

   task automatic test_rotation();
      do_reset();
      d0 = 1'b1; d1 = 1'b0; d2 = 1'b1;
      req = 3'b111;
      tick();
      n_chk++;
      if (gnt !== 3'b001 || sel !== 2'b00 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rot_first: gnt=%b sel=%b valid=%b want 001 00 0",
                  gnt, sel, valid);
      end
      for (int i = 2; i <= 8; i++) begin
         tick();
         n_chk++;
         if (gnt !== 3'b001 || valid !== 1'b1 || y !== 1'b1) begin
            n_fail++;
            $display("FAIL rot_hold0 c%0d: gnt=%b valid=%b y=%b want 001 1 1",
                     i, gnt, valid, y);
         end
      end
      tick();
      n_chk++;
      if (gnt !== 3'b010 || sel !== 2'b01) begin
         n_fail++;
         $display("FAIL rot_to1: gnt=%b sel=%b want 010 01", gnt, sel);
      end
      for (int i = 2; i <= 8; i++) tick();
      n_chk++;
      if (gnt !== 3'b010 || y !== 1'b0) begin
         n_fail++;
         $display("FAIL rot_hold1: gnt=%b y=%b want 010 0", gnt, y);
      end
      tick();
      n_chk++;
      if (gnt !== 3'b100 || sel !== 2'b10 || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rot_to2: gnt=%b sel=%b valid=%b want 100 10 1",
                  gnt, sel, valid);
      end
      for (int i = 2; i <= 8; i++) tick();
      tick();
      n_chk++;
      if (gnt !== 3'b001 || sel !== 2'b00) begin
         n_fail++;
         $display("FAIL rot_wrap: gnt=%b sel=%b want 001 00", gnt, sel);
      end
   endtask

   task automatic test_hold();
      do_reset();
      d0 = 1'b1;
      req = 3'b001;
      tick();
      n_chk++;
      if (gnt !== 3'b001 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_grant: gnt=%b valid=%b want 001 0", gnt, valid);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         n_chk++;
         if (gnt !== 3'b001 || y !== 1'b1 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold c%0d: gnt=%b y=%b valid=%b want 001 1 1",
                     i, gnt, y, valid);
         end
      end
      req = 3'b011;
      tick();
      n_chk++;
      if (gnt !== 3'b010) begin
         n_fail++;
         $display("FAIL hold_sat_rotate: gnt=%b want 010", gnt);
      end
   endtask

   task automatic test_drop_and_idle();
      do_reset();
      d0 = 1'b0; d1 = 1'b0; d2 = 1'b1;
      req = 3'b010;
      tick();
      n_chk++;
      if (gnt !== 3'b010 || sel !== 2'b01) begin
         n_fail++;
         $display("FAIL drop_first: gnt=%b sel=%b want 010 01", gnt, sel);
      end
      tick();
      req = 3'b101;
      tick();
      n_chk++;
      if (gnt !== 3'b100 || sel !== 2'b10 || valid !== 1'b1 || y !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_switch: gnt=%b sel=%b valid=%b y=%b want 100 10 1 0",
                  gnt, sel, valid, y);
      end
      tick();
      n_chk++;
      if (gnt !== 3'b100 || valid !== 1'b1 || y !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_data: gnt=%b valid=%b y=%b want 100 1 1",
                  gnt, valid, y);
      end
      req = 3'b000;
      tick();
      n_chk++;
      if (gnt !== 3'b000 || sel !== 2'b10 || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_gnt: gnt=%b sel=%b valid=%b want 000 10 1",
                  gnt, sel, valid);
      end
      tick();
      n_chk++;
      if (gnt !== 3'b000 || sel !== 2'b10 || valid !== 1'b0 || y !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_valid: gnt=%b sel=%b valid=%b y=%b want 000 10 0 0",
                  gnt, sel, valid, y);
      end
      req = 3'b011;
      tick();
      n_chk++;
      if (gnt !== 3'b001) begin
         n_fail++;
         $display("FAIL idle_regrant: gnt=%b want 001", gnt);
      end
   endtask

   task automatic test_swap_same_cycle();
      do_reset();
      req = 3'b001;
      tick();
      tick();
      req = 3'b100;
      tick();
      n_chk++;
      if (gnt !== 3'b100 || sel !== 2'b10) begin
         n_fail++;
         $display("FAIL swap: gnt=%b sel=%b want 100 10", gnt, sel);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      d1 = 1'b1;
      req = 3'b010;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if (gnt !== 3'b000 || y !== 1'b0 || valid !== 1'b0 || sel !== 2'b00) begin
         n_fail++;
         $display("FAIL async_rst: gnt=%b y=%b valid=%b sel=%b want 000 0 0 00",
                  gnt, y, valid, sel);
      end
      tick();
      rst = 1'b0;
      req = 3'b110;
      tick();
      n_chk++;
      if (gnt !== 3'b010) begin
         n_fail++;
         $display("FAIL rst_prio: gnt=%b want 010", gnt);
      end
   endtask

`ifdef MUX3_ARB_LOCK_EN
   task automatic test_lock();
      do_reset();
      lock = 1'b1;
      req = 3'b011;
      tick();
      for (int i = 0; i < 20; i++) begin
         tick();
         n_chk++;
         if (gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL lock_hold c%0d: gnt=%b want 001", i, gnt);
         end
      end
      lock = 1'b0;
      tick();
      n_chk++;
      if (gnt !== 3'b010) begin
         n_fail++;
         $display("FAIL lock_release: gnt=%b want 010", gnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_rotation();
      test_hold();
      test_drop_and_idle();
      test_swap_same_cycle();
      test_async_reset();
`ifdef MUX3_ARB_LOCK_EN
      test_lock();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux3_rr_arbiter.md
MUX3_RR_ARBITER -- requirements
Module: mux3_rr_arbiter

Interface
REQ-001 Parameter SHALL be: MAX_HOLD, 8, max consecutive grant cycles before forced rotation when others wait (range 1..255).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  3  request per input; req[i] belongs to d<i>.
- d0  in  1  data of requester 0.
- d1  in  1  data of requester 1.
- d2  in  1  data of requester 2.
- gnt  out  3  one-hot grant, registered.
- sel  out  2  mux select of current/last owner: 00=d0, 01=d1, 10=d2.
- y  out  1  registered selected data.
- valid  out  1  y carries owner data.
REQ-003 Design SHALL use one clock (clk); reset rst SHALL be asynchronous and active-high.

Function
REQ-004 Encoding 11 SHALL never appear on sel.
REQ-005 gnt SHALL be zero or one-hot; sel SHALL equal index of set gnt bit whenever gnt!=0.
REQ-006 States SHALL be IDLE (gnt=0) and BUSY (one owner).
REQ-007 Round-robin pointer last SHALL hold last granted index; search order SHALL be last+1, last+2, last (mod 3).
REQ-008 IDLE with req!=0 SHALL grant the winner at the next edge, enter BUSY, set hold count to 1, update last.
REQ-009 BUSY with req[owner]=0 SHALL, at next edge, grant next winner among others (count=1) if any pending, else return to IDLE with gnt=0.
REQ-010 BUSY with req[owner]=1, count=MAX_HOLD and another req pending SHALL rotate to next winner at next edge, no idle cycle.
REQ-011 BUSY with req[owner]=1 and no other req SHALL hold grant; count SHALL saturate at MAX_HOLD.
REQ-012 Otherwise BUSY SHALL keep owner and increment count.
REQ-013 y and valid SHALL update each edge: valid<=(gnt!=0), y<=gnt!=0 ? d[sel] : 0; one-cycle latency from gnt/sel to y.
REQ-014 In IDLE sel SHALL hold the last owner's index.
REQ-015 Requests deasserting and asserting in the same cycle SHALL be resolved by REQ-009 using the current req vector.

Reset
REQ-016 On rst assertion, without waiting for clk: gnt=000, sel=00, y=0, valid=0, state=IDLE, count=0, last=2.
REQ-017 Reset mid-grant SHALL drop the grant immediately; first grant after release SHALL follow REQ-008 with priority 0,1,2.

Configuration
REQ-018 Macro MUX3_ARB_LOCK_EN SHALL add input port lock (1 bit, after req).
REQ-019 With MUX3_ARB_LOCK_EN, lock=1 while req[owner]=1 SHALL suppress REQ-010 rotation; lock SHALL have no effect in IDLE or when req[owner]=0.
REQ-020 Without MUX3_ARB_LOCK_EN, the lock port SHALL not exist and rotation SHALL follow REQ-010 alone.

Structure
REQ-021 Package mux3_arb_pkg SHALL hold state enum (IDLE, BUSY), SEL_D0=00, SEL_D1=01, SEL_D2=10 and the index-to-one-hot/ one-hot-to-sel constants.
REQ-022 Sub-module mux3_rr_pick (combinational: req, last, exclude-owner flag -> winner index, found) SHALL implement REQ-007.

Verification
REQ-023 Reset release, req=111 -> gnt order 001,010,100 at successive MAX_HOLD boundaries; first grant one cycle after req.
REQ-024 Owner 0, d0=1, req=001 held 20 cycles, MAX_HOLD=8 -> gnt stays 001, y=1, valid=1 from cycle after grant.
REQ-025 Owner 1 drops req while req=101 -> next edge gnt=100 (after 1 wraps to 2), no gap in valid.
REQ-026 All req drop -> gnt=000 next edge, valid=0 one edge later, sel unchanged.
REQ-027 rst pulse mid-BUSY between edges -> gnt=000, y=0, valid=0 before next clk edge.
REQ-028 With MUX3_ARB_LOCK_EN, lock=1, req=011, owner 0 -> no rotation past count 8; lock=0 -> gnt=010 next edge.
